// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus for the fetch stage.
// The fetch stage is the master; the memory is the slave.
interface if_stage_if;
  logic        imem_read_o;
  logic [31:0] imem_address_o;
  logic        imem_resp_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_read_o,
    output imem_address_o,
    input  imem_resp_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_read_o,
    input  imem_address_o,
    output imem_resp_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding request, redirect discard.
// Optional one-entry fetch buffer enabled by macro IF_FETCH_BUFFER_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  if_stage_if.master  imem,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        load_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] tgt;
  logic [31:0] next_addr;

`ifdef IF_FETCH_BUFFER_EN
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
`endif

  assign tgt       = {redirect_pc_i[31:2], 2'b00};
  assign next_addr = req_addr_q + 32'd4;

  // Bus request and delivered-instruction outputs from current state.
  always_comb begin
    imem.imem_read_o    = (state_q == REQ) || (state_q == DISCARD);
    imem.imem_address_o = req_addr_q;
    valid_o = 1'b0;
    pc_o    = '0;
    instr_o = '0;
    unique case (state_q)
      REQ: begin
        if (imem.imem_resp_i) begin
          valid_o = 1'b1;
          pc_o    = req_addr_q;
          instr_o = imem.imem_rdata_i;
        end
      end
      HOLD: begin
`ifdef IF_FETCH_BUFFER_EN
        valid_o = 1'b1;
        pc_o    = buf_pc_q;
        instr_o = buf_instr_q;
`endif
      end
      default: ;
    endcase
    load_o = valid_o & ~stall_i & ~redirect_i;
  end

  // Next state, PC and request address; redirect always wins.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
`ifdef IF_FETCH_BUFFER_EN
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
`endif
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (imem.imem_resp_i) begin
          if (redirect_i) begin
            pc_d       = tgt;
            req_addr_d = tgt;
          end else if (!stall_i) begin
            pc_d       = next_addr;
            req_addr_d = next_addr;
          end else begin
`ifdef IF_FETCH_BUFFER_EN
            buf_instr_d = imem.imem_rdata_i;
            buf_pc_d    = req_addr_q;
            state_d     = HOLD;
`endif
          end
        end else if (redirect_i) begin
          pc_d    = tgt;
          state_d = DISCARD;
        end
      end
      HOLD: begin
`ifdef IF_FETCH_BUFFER_EN
        if (redirect_i) begin
          pc_d       = tgt;
          req_addr_d = tgt;
          state_d    = REQ;
        end else if (!stall_i) begin
          pc_d       = buf_pc_q + 32'd4;
          req_addr_d = buf_pc_q + 32'd4;
          state_d    = REQ;
        end
`else
        state_d = REQ;
`endif
      end
      DISCARD: begin
        if (redirect_i) begin
          pc_d = tgt;
        end
        if (imem.imem_resp_i) begin
          req_addr_d = redirect_i ? tgt : pc_q;
          state_d    = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
`ifdef IF_FETCH_BUFFER_EN
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
`ifdef IF_FETCH_BUFFER_EN
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then random
// stimulus against a behavioural fetch model.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        valid_o;
  logic        load_o;

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h00000060)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem         (bus),
    .pc_o         (pc_o),
    .instr_o      (instr_o),
    .valid_o      (valid_o),
    .load_o       (load_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: what the fetcher is doing, in words.
  typedef enum int {M_IDLE, M_FETCH, M_HELD, M_DROP} mode_t;
  mode_t       m_mode = M_IDLE;
  logic [31:0] m_next = 32'h60;
  logic [31:0] m_addr = 32'h60;
  logic [31:0] m_hpc  = 32'h0;
  logic [31:0] m_hins = 32'h0;

  // Sampled DUT outputs of the latest step.
  logic        s_read, s_valid, s_load;
  logic [31:0] s_addr, s_pc, s_ins;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic st, input logic rd,
                      input logic [31:0] rpc, input logic rs);
    logic        e_read, e_valid, e_load;
    logic [31:0] e_pc, e_ins, tgt;
    @(negedge clk);
    rst           = r;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    bus.imem_resp_i  = rs;
    bus.imem_rdata_i = rs ? mem_word(m_addr) : 32'hBAD0BAD0;
    #1;
    s_read  = bus.imem_read_o;
    s_addr  = bus.imem_address_o;
    s_valid = valid_o;
    s_load  = load_o;
    s_pc    = pc_o;
    s_ins   = instr_o;
    e_read  = (m_mode == M_FETCH) || (m_mode == M_DROP);
    e_valid = 1'b0;
    e_pc    = 32'h0;
    e_ins   = 32'h0;
    if (m_mode == M_FETCH && rs) begin
      e_valid = 1'b1;
      e_pc    = m_addr;
      e_ins   = mem_word(m_addr);
    end
    if (m_mode == M_HELD) begin
      e_valid = 1'b1;
      e_pc    = m_hpc;
      e_ins   = m_hins;
    end
    e_load = e_valid && !st && !rd;
    chk("read", {31'b0, s_read}, {31'b0, e_read});
    if (e_read) chk("addr", s_addr, m_addr);
    chk("valid", {31'b0, s_valid}, {31'b0, e_valid});
    chk("load", {31'b0, s_load}, {31'b0, e_load});
    if (e_valid || m_mode == M_IDLE) begin
      chk("pc_o", s_pc, e_pc);
      chk("instr_o", s_ins, e_ins);
    end
    @(posedge clk);
    tgt = rpc & ~32'h3;
    if (!r) begin
      m_mode = M_IDLE;
      m_next = 32'h60;
      m_addr = 32'h60;
    end else begin
      case (m_mode)
        M_IDLE: m_mode = M_FETCH;
        M_FETCH: begin
          if (rd && rs) begin
            m_next = tgt;
            m_addr = tgt;
          end else if (rd) begin
            m_next = tgt;
            m_mode = M_DROP;
          end else if (rs && !st) begin
            m_addr = m_addr + 4;
            m_next = m_addr;
          end else if (rs) begin
`ifdef IF_FETCH_BUFFER_EN
            m_hpc  = m_addr;
            m_hins = mem_word(m_addr);
            m_mode = M_HELD;
`endif
          end
        end
        M_HELD: begin
          if (rd) begin
            m_next = tgt;
            m_addr = tgt;
            m_mode = M_FETCH;
          end else if (!st) begin
            m_next = m_hpc + 4;
            m_addr = m_hpc + 4;
            m_mode = M_FETCH;
          end
        end
        M_DROP: begin
          if (rd) m_next = tgt;
          if (rs) begin
            m_addr = m_next;
            m_mode = M_FETCH;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  // Reset, then sit in IDLE for one cycle while a stray response arrives.
  task automatic restart();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    rst = 1'b0;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    bus.imem_resp_i = 1'b0;
    bus.imem_rdata_i = 32'h0;
    repeat (2) @(posedge clk);

    // Reset state.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_read", {31'b0, s_read}, 32'h0);
    chk("rst_valid", {31'b0, s_valid}, 32'h0);
    chk("rst_load", {31'b0, s_load}, 32'h0);
    chk("rst_pc", s_pc, 32'h0);
    chk("rst_instr", s_ins, 32'h0);

    // Zero-latency stream.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("idle_valid", {31'b0, s_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("stream_addr", s_addr, 32'h60 + 32'(4 * i));
      chk("stream_load", {31'b0, s_load}, 32'h1);
      chk("stream_pc", s_pc, 32'h60 + 32'(4 * i));
    end

    // Three-cycle response latency.
    restart();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("lat_addr", s_addr, 32'h60);
      chk("lat_valid", {31'b0, s_valid}, 32'h0);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("lat_addr4", s_addr, 32'h60);
    chk("lat_valid4", {31'b0, s_valid}, 32'h1);

    // Redirect while 0x64 is outstanding.
    restart();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h1003, 1'b0);
    chk("rdr_addr", s_addr, 32'h64);
    chk("rdr_load", {31'b0, s_load}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("disc_addr", s_addr, 32'h64);
    chk("disc_valid", {31'b0, s_valid}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("disc_load", {31'b0, s_load}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("rdr_new_addr", s_addr, 32'h1000);
    chk("rdr_new_pc", s_pc, 32'h1000);
    chk("rdr_new_load", {31'b0, s_load}, 32'h1);

    // Stall on the 0x68 response.
    restart();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("stl_addr", s_addr, 32'h68);
    chk("stl_load", {31'b0, s_load}, 32'h0);
`ifdef IF_FETCH_BUFFER_EN
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("hold_read", {31'b0, s_read}, 32'h0);
    chk("hold_pc", s_pc, 32'h68);
    chk("hold_load", {31'b0, s_load}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("hold_rel_pc", s_pc, 32'h68);
    chk("hold_rel_load", {31'b0, s_load}, 32'h1);
`else
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("refetch_addr", s_addr, 32'h68);
    chk("refetch_load", {31'b0, s_load}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("refetch_pc", s_pc, 32'h68);
    chk("refetch_rel_load", {31'b0, s_load}, 32'h1);
`endif
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("after_stall_addr", s_addr, 32'h6C);

    // Reset during a pending request, late response afterwards.
    restart();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("late_read", {31'b0, s_read}, 32'h0);
    chk("late_load", {31'b0, s_load}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("post_rst_addr", s_addr, 32'h60);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      logic r, st, rd, rs;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 49) != 0);
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      rpc = $urandom;
      if (m_mode == M_FETCH || m_mode == M_DROP)
        rs = ($urandom_range(0, 1) == 1);
      else if (m_mode == M_IDLE)
        rs = ($urandom_range(0, 3) == 0);
      else
        rs = 1'b0;
      step(r, st, rd, rpc, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
